// File: rtl/platform_scroll_ctrl.sv
// rtl/platform_scroll_ctrl.sv - per-frame platform scroll/respawn controller owning the position table
// Optional: define PLAT_SCORE_EN to accumulate a saturating height score from applied scroll.
module platform_scroll_ctrl #(
  parameter int          NUM_PLAT    = 16,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter int          PLAT_HALF   = 4,
  parameter int          SCROLL_LINE = 160,
  parameter int          MAX_STEP    = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_tick,
  input  logic [9:0]              BallY,
  output logic [10*NUM_PLAT-1:0]  plat_x_flat,
  output logic [10*NUM_PLAT-1:0]  plat_y_flat,
  output logic [9:0]              scroll_amt_o,
  output logic                    busy,
  output logic                    update_done,
  output logic [15:0]             score
);

  localparam int          IDX_W       = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam logic [10:0] RESPAWN_LIM = 11'(SCREEN_H - 1 + PLAT_HALF);
  localparam logic [9:0]  X_RANGE     = 10'(SCREEN_W - 64);
  localparam logic [9:0]  LAST_IDX    = 10'(NUM_PLAT - 1);

  typedef enum logic [1:0] {IDLE, CALC, UPDATE, DONE} state_t;

  state_t           state_q, state_d;
  logic [9:0]       bally_q, bally_d;
  logic [9:0]       amt_q, amt_d;
  logic [9:0]       scroll_amt_q, scroll_amt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [9:0]       x_q [NUM_PLAT];
  logic [9:0]       x_d [NUM_PLAT];
  logic [9:0]       y_q [NUM_PLAT];
  logic [9:0]       y_d [NUM_PLAT];

  logic [10:0]      new_y;
  logic [15:0]      lfsr_nxt;
  logic [9:0]       rand_x;
  logic [9:0]       climb;

  function automatic logic [9:0] init_x(input int i);
    return 10'(32 + ((i * 149) % (SCREEN_W - 64)));
  endfunction

  function automatic logic [9:0] init_y(input int i);
    return 10'(SCREEN_H - 16 - 30 * i);
  endfunction

  always_comb begin
    state_d      = state_q;
    bally_d      = bally_q;
    amt_d        = amt_q;
    scroll_amt_d = scroll_amt_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    x_d          = x_q;
    y_d          = y_q;

    new_y    = {1'b0, y_q[idx_q]} + {1'b0, amt_q};
    lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Fold the 10-bit LFSR slice into the usable X span with one conditional subtract.
    rand_x   = (lfsr_nxt[9:0] >= X_RANGE) ? (lfsr_nxt[9:0] - X_RANGE) : lfsr_nxt[9:0];
    climb    = 10'(SCROLL_LINE) - bally_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          bally_d = BallY;
          state_d = CALC;
        end
      end
      CALC: begin
        if (bally_q < 10'(SCROLL_LINE)) begin
          amt_d   = (climb > 10'(MAX_STEP)) ? 10'(MAX_STEP) : climb;
          idx_d   = '0;
          state_d = UPDATE;
        end else begin
          amt_d        = '0;
          scroll_amt_d = '0;
          state_d      = DONE;
        end
      end
      UPDATE: begin
        if (new_y > RESPAWN_LIM) begin
          lfsr_d       = lfsr_nxt;
          y_d[idx_q]   = 10'(PLAT_HALF);
          x_d[idx_q]   = 10'd32 + rand_x;
        end else begin
          y_d[idx_q]   = new_y[9:0];
        end
        if (10'(idx_q) == LAST_IDX) begin
          scroll_amt_d = amt_q;
          state_d      = DONE;
        end else begin
          idx_d        = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      bally_q      <= '0;
      amt_q        <= '0;
      scroll_amt_q <= '0;
      idx_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      for (int i = 0; i < NUM_PLAT; i++) begin
        x_q[i] <= init_x(i);
        y_q[i] <= init_y(i);
      end
    end else begin
      state_q      <= state_d;
      bally_q      <= bally_d;
      amt_q        <= amt_d;
      scroll_amt_q <= scroll_amt_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_flat
    assign plat_x_flat[10*g +: 10] = x_q[g];
    assign plat_y_flat[10*g +: 10] = y_q[g];
  end

  assign scroll_amt_o = scroll_amt_q;
  assign busy         = (state_q != IDLE);
  assign update_done  = (state_q == DONE);

`ifdef PLAT_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score_q} + {7'b0, scroll_amt_q};
    score_d   = score_q;
    if (state_q == DONE) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_platform_scroll_ctrl.sv
// tb/tb_platform_scroll_ctrl.sv - directed self-checking bench for platform_scroll_ctrl
module tb_platform_scroll_ctrl;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic [9:0]   BallY = 10'd0;
  logic [159:0] plat_x_flat;
  logic [159:0] plat_y_flat;
  logic [9:0]   scroll_amt_o;
  logic         busy;
  logic         update_done;
  logic [15:0]  score;

  int checks = 0;
  int failures = 0;
  int lat;
  int pulses;

  platform_scroll_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .BallY        (BallY),
    .plat_x_flat  (plat_x_flat),
    .plat_y_flat  (plat_y_flat),
    .scroll_amt_o (scroll_amt_o),
    .busy         (busy),
    .update_done  (update_done),
    .score        (score)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] px(input int i);
    return plat_x_flat[10*i +: 10];
  endfunction

  function automatic logic [9:0] py(input int i);
    return plat_y_flat[10*i +: 10];
  endfunction

  function automatic logic [15:0] exp_score(input int v);
`ifdef PLAT_SCORE_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  task automatic do_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    frame_tick = 1'b0;
    @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  // Returns the cycle index (tick edge = t) at which update_done was seen; stray_at injects a tick while busy.
  task automatic run_frame(input logic [9:0] by, input int stray_at, output int l);
    @(posedge Clk);
    #1 BallY = by;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1 frame_tick = 1'b0;
    l = 1;
    check_eq("busy_t1", 32'(busy), 32'd1);
    while (update_done !== 1'b1 && l < 40) begin
      frame_tick = (l == stray_at);
      @(posedge Clk);
      #1 l++;
    end
    frame_tick = 1'b0;
    @(posedge Clk);
    #1 check_eq("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1 if (update_done === 1'b1) c++;
    end
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    check_eq("rst_x0", 32'(px(0)), 32'd32);
    check_eq("rst_y0", 32'(py(0)), 32'd464);
    check_eq("rst_x1", 32'(px(1)), 32'd181);
    check_eq("rst_y1", 32'(py(1)), 32'd434);
    check_eq("rst_x15", 32'(px(15)), 32'd539);
    check_eq("rst_y15", 32'(py(15)), 32'd14);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(update_done), 32'd0);
    check_eq("rst_scroll", 32'(scroll_amt_o), 32'd0);
    check_eq("rst_score", 32'(score), 32'd0);

    run_frame(10'd200, -1, lat);
    check_eq("noscroll_lat", 32'(lat), 32'd2);
    check_eq("noscroll_y0", 32'(py(0)), 32'd464);
    check_eq("noscroll_amt", 32'(scroll_amt_o), 32'd0);

    run_frame(10'd160, -1, lat);
    check_eq("line_lat", 32'(lat), 32'd2);
    check_eq("line_y15", 32'(py(15)), 32'd14);

    run_frame(10'd155, -1, lat);
    check_eq("s5_lat", 32'(lat), 32'd18);
    check_eq("s5_y0", 32'(py(0)), 32'd469);
    check_eq("s5_y15", 32'(py(15)), 32'd19);
    check_eq("s5_x0", 32'(px(0)), 32'd32);
    check_eq("s5_amt", 32'(scroll_amt_o), 32'd5);
    check_eq("s5_score", 32'(score), 32'(exp_score(5)));

    do_reset();
    check_eq("rst2_score", 32'(score), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      run_frame(10'd100, -1, lat);
      check_eq("s8_lat", 32'(lat), 32'd18);
      check_eq("s8_amt", 32'(scroll_amt_o), 32'd8);
      check_eq("s8_score", 32'(score), 32'(exp_score(8 * k)));
      if (k == 1) check_eq("t1_y0", 32'(py(0)), 32'd472);
      if (k == 2) check_eq("t2_y0", 32'(py(0)), 32'd480);
      if (k == 3) begin
        check_eq("t3_x0", 32'(px(0)), 32'd80);
        check_eq("t3_y0", 32'(py(0)), 32'd4);
        check_eq("t3_y1", 32'(py(1)), 32'd458);
      end
      if (k == 6) begin
        check_eq("t6_y1_edge", 32'(py(1)), 32'd482);
        check_eq("t6_x1_edge", 32'(px(1)), 32'd181);
      end
      if (k == 7) begin
        check_eq("t7_x1", 32'(px(1)), 32'd344);
        check_eq("t7_y1", 32'(py(1)), 32'd4);
        check_eq("t7_y0", 32'(py(0)), 32'd36);
        check_eq("t7_x0", 32'(px(0)), 32'd80);
      end
    end

    @(posedge Clk);
    #1 BallY = 10'd100;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1 frame_tick = 1'b0;
    repeat (7) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check_eq("midrst_x0", 32'(px(0)), 32'd32);
    check_eq("midrst_y0", 32'(py(0)), 32'd464);
    check_eq("midrst_x1", 32'(px(1)), 32'd181);
    check_eq("midrst_y1", 32'(py(1)), 32'd434);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(update_done), 32'd0);
    check_eq("midrst_score", 32'(score), 32'd0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    count_done(25, pulses);
    check_eq("midrst_no_pulse", 32'(pulses), 32'd0);
    for (int k = 1; k <= 3; k++) run_frame(10'd100, -1, lat);
    check_eq("seed_x0", 32'(px(0)), 32'd80);
    check_eq("seed_y0", 32'(py(0)), 32'd4);

    do_reset();
    run_frame(10'd100, 4, lat);
    check_eq("stray_lat", 32'(lat), 32'd18);
    count_done(25, pulses);
    check_eq("stray_no_pulse", 32'(pulses), 32'd0);
    check_eq("stray_y0", 32'(py(0)), 32'd472);
    check_eq("stray_y15", 32'(py(15)), 32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
